// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave transmit path: controller states,
// SDA drive encodings and the bit-counter rollover value.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        ACK_WAIT,
        ACK_HOLD
    } tx_state_t;

    localparam logic SDA_RELEASE = 1'b0;
    localparam logic SDA_DRIVE   = 1'b1;

    localparam int          BIT_CNT_BITS = 4;
    localparam logic [3:0]  BIT_ROLLOVER = 4'd8;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear; counts 1..rollover_val and wraps back to 1.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            if (count_q == rollover_val) begin
                count_d = {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/tx_ctrl.sv
// I2C slave read-transfer controller: loads bytes from the TX FIFO, shifts
// them out on SCL falling edges and handles the master ACK/NACK bit.
module tx_ctrl
    import i2c_pkg::*;
(
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start_read,
    input  logic       stop_found,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic       sda_in,
    input  logic       fifo_empty,
    output logic       load_data,
    output logic       tx_enable,
    output logic       read_enable,
    output logic       sda_drive,
    output logic       master_nack,
    output logic       underrun,
    output logic [7:0] byte_count
);

    tx_state_t  state_q, state_d;
    logic       ack_q, ack_d;
    logic       nack_q, nack_d;
    logic [7:0] byte_count_q, byte_count_d;

    logic                    fall_eff;
    logic                    cnt_clear;
    logic                    cnt_en;
    logic [BIT_CNT_BITS-1:0] bit_cnt;

    // A rising edge in the same cycle masks the falling edge.
    assign fall_eff = falling_edge_found & ~rising_edge_found;

    flex_counter #(
        .NUM_CNT_BITS(BIT_CNT_BITS)
    ) u_bit_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .rollover_val (BIT_ROLLOVER),
        .count_out    (bit_cnt)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            ack_q        <= 1'b1;
            nack_q       <= 1'b0;
            byte_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            nack_q       <= nack_d;
            byte_count_q <= byte_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ack_d        = ack_q;
        nack_d       = 1'b0;
        byte_count_d = byte_count_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;
        if (stop_found) begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_read) begin
                        state_d      = LOAD;
                        byte_count_d = 8'd0;
                    end
                end
                LOAD: begin
                    cnt_clear = 1'b1;
                    state_d   = SEND;
                end
                SEND: begin
                    if (fall_eff) begin
                        cnt_en = 1'b1;
                        if (bit_cnt == BIT_ROLLOVER - 4'd1) begin
                            state_d = ACK_WAIT;
                        end
                    end
                end
                ACK_WAIT: begin
                    if (rising_edge_found) begin
                        ack_d   = sda_in;
                        state_d = ACK_HOLD;
                    end
                end
                ACK_HOLD: begin
                    if (fall_eff) begin
                        if (!ack_q) begin
                            byte_count_d = byte_count_q + 8'd1;
                            state_d      = LOAD;
                        end else begin
                            // Registered so the pulse comes from state, not from the SCL edge input.
                            nack_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign load_data   = (state_q == LOAD);
    assign tx_enable   = (state_q == SEND);
    assign read_enable = (state_q == LOAD) & ~fifo_empty;
    assign underrun    = (state_q == LOAD) & fifo_empty;
    assign sda_drive   = ((state_q == LOAD) || (state_q == SEND)) ? SDA_DRIVE : SDA_RELEASE;
    assign master_nack = nack_q;
    assign byte_count  = byte_count_q;

endmodule

// File: tb/tb_tx_ctrl.sv
// Directed self-checking bench for tx_ctrl.
module tb_tx_ctrl;

    logic       clk = 1'b0;
    logic       n_rst = 1'b1;
    logic       start_read = 1'b0;
    logic       stop_found = 1'b0;
    logic       rising_edge_found = 1'b0;
    logic       falling_edge_found = 1'b0;
    logic       sda_in = 1'b1;
    logic       fifo_empty = 1'b0;
    logic       load_data, tx_enable, read_enable, sda_drive, master_nack, underrun;
    logic [7:0] byte_count;
    logic [13:0] outs;

    int n_cmp = 0;
    int n_bad = 0;
    int load_cnt = 0;
    int ren_cnt = 0;

    tx_ctrl dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .start_read         (start_read),
        .stop_found         (stop_found),
        .rising_edge_found  (rising_edge_found),
        .falling_edge_found (falling_edge_found),
        .sda_in             (sda_in),
        .fifo_empty         (fifo_empty),
        .load_data          (load_data),
        .tx_enable          (tx_enable),
        .read_enable        (read_enable),
        .sda_drive          (sda_drive),
        .master_nack        (master_nack),
        .underrun           (underrun),
        .byte_count         (byte_count)
    );

    always #5 clk = ~clk;

    // [13] load [12] tx_en [11] read_en [10] sda_drive [9] nack [8] underrun [7:0] byte_count
    assign outs = {load_data, tx_enable, read_enable, sda_drive, master_nack, underrun, byte_count};

    always @(negedge clk) begin
        if (load_data) load_cnt++;
        if (read_enable) ren_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fall();
        falling_edge_found = 1'b1;
        tick();
        falling_edge_found = 1'b0;
    endtask

    task automatic do_rise();
        rising_edge_found = 1'b1;
        tick();
        rising_edge_found = 1'b0;
    endtask

    task automatic do_start();
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
    endtask

    task automatic do_stop();
        stop_found = 1'b1;
        tick();
        stop_found = 1'b0;
    endtask

    task automatic send_bits(input int n);
        for (int i = 0; i < n; i++) begin
            do_fall();
            tick();
        end
    endtask

    task automatic test_reset();
        #2 n_rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (outs !== 14'h0000) begin
            n_bad++;
            $display("FAIL reset_hold outs=%h expected=%h", outs, 14'h0000);
        end
        n_rst = 1'b1;
        tick();
        $display("reset: outs=%h", outs);
        n_cmp++;
        if (outs !== 14'h0000) begin
            n_bad++;
            $display("FAIL reset_release outs=%h expected=%h", outs, 14'h0000);
        end
    endtask

    task automatic test_ack_byte();
        int l0, r0;
        l0 = load_cnt;
        r0 = ren_cnt;
        fifo_empty = 1'b0;
        do_start();
        n_cmp++;
        if (outs !== 14'h2C00) begin
            n_bad++;
            $display("FAIL ack_load outs=%h expected=%h", outs, 14'h2C00);
        end
        tick();
        n_cmp++;
        if (outs !== 14'h1400) begin
            n_bad++;
            $display("FAIL ack_send outs=%h expected=%h", outs, 14'h1400);
        end
        for (int k = 0; k < 8; k++) begin
            do_fall();
            tick();
            if (k < 7) begin
                n_cmp++;
                if ({tx_enable, sda_drive} !== 2'b11) begin
                    n_bad++;
                    $display("FAIL ack_bit%0d tx_en/sda=%b expected=11", k, {tx_enable, sda_drive});
                end
            end
        end
        n_cmp++;
        if (outs !== 14'h0000) begin
            n_bad++;
            $display("FAIL ack_wait outs=%h expected=%h", outs, 14'h0000);
        end
        n_cmp++;
        if ((load_cnt - l0) != 1 || (ren_cnt - r0) != 1) begin
            n_bad++;
            $display("FAIL ack_pulses loads=%0d reads=%0d expected=1/1", load_cnt - l0, ren_cnt - r0);
        end
        sda_in = 1'b0;
        do_rise();
        tick();
        do_fall();
        $display("ack_byte: outs=%h byte_count=%0d", outs, byte_count);
        n_cmp++;
        if (outs !== 14'h2C01) begin
            n_bad++;
            $display("FAIL ack_second_load outs=%h expected=%h", outs, 14'h2C01);
        end
        do_stop();
        n_cmp++;
        if (outs !== 14'h0001) begin
            n_bad++;
            $display("FAIL ack_stop_retain outs=%h expected=%h", outs, 14'h0001);
        end
    endtask

    task automatic test_nack();
        int l0;
        l0 = load_cnt;
        do_start();
        n_cmp++;
        if (outs !== 14'h2C00) begin
            n_bad++;
            $display("FAIL nack_load_clear outs=%h expected=%h", outs, 14'h2C00);
        end
        tick();
        send_bits(8);
        sda_in = 1'b1;
        do_rise();
        tick();
        do_fall();
        $display("nack: outs=%h", outs);
        n_cmp++;
        if (outs !== 14'h0200) begin
            n_bad++;
            $display("FAIL nack_pulse outs=%h expected=%h", outs, 14'h0200);
        end
        tick();
        n_cmp++;
        if (outs !== 14'h0000 || (load_cnt - l0) != 1) begin
            n_bad++;
            $display("FAIL nack_idle outs=%h loads=%0d expected=%h/1", outs, load_cnt - l0, 14'h0000);
        end
    endtask

    task automatic test_underrun();
        fifo_empty = 1'b1;
        do_start();
        $display("underrun: outs=%h", outs);
        n_cmp++;
        if (outs !== 14'h2500) begin
            n_bad++;
            $display("FAIL underrun_load outs=%h expected=%h", outs, 14'h2500);
        end
        do_stop();
        fifo_empty = 1'b0;
        n_cmp++;
        if (outs !== 14'h0000) begin
            n_bad++;
            $display("FAIL underrun_stop outs=%h expected=%h", outs, 14'h0000);
        end
    endtask

    task automatic test_stop();
        int l0;
        l0 = load_cnt;
        do_start();
        tick();
        send_bits(3);
        do_stop();
        $display("stop: outs=%h", outs);
        n_cmp++;
        if (outs !== 14'h0000) begin
            n_bad++;
            $display("FAIL stop_idle outs=%h expected=%h", outs, 14'h0000);
        end
        send_bits(6);
        sda_in = 1'b0;
        do_rise();
        do_fall();
        tick();
        n_cmp++;
        if ((load_cnt - l0) != 1 || sda_drive !== 1'b0) begin
            n_bad++;
            $display("FAIL stop_no_reload loads=%0d sda=%b expected=1/0", load_cnt - l0, sda_drive);
        end
    endtask

    task automatic test_edge_rules();
        do_start();
        tick();
        do_start();
        n_cmp++;
        if (outs !== 14'h1400) begin
            n_bad++;
            $display("FAIL start_ignored outs=%h expected=%h", outs, 14'h1400);
        end
        send_bits(3);
        rising_edge_found = 1'b1;
        falling_edge_found = 1'b1;
        tick();
        rising_edge_found = 1'b0;
        falling_edge_found = 1'b0;
        send_bits(4);
        n_cmp++;
        if (outs !== 14'h1400) begin
            n_bad++;
            $display("FAIL both_edges outs=%h expected=%h", outs, 14'h1400);
        end
        send_bits(1);
        $display("edge_rules: outs=%h", outs);
        n_cmp++;
        if (outs !== 14'h0000) begin
            n_bad++;
            $display("FAIL eighth_bit outs=%h expected=%h", outs, 14'h0000);
        end
        do_stop();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_bc;
        do_start();
        tick();
        for (int i = 0; i < 256; i++) begin
            send_bits(8);
            sda_in = 1'b0;
            do_rise();
            do_fall();
            exp_bc = 8'(i + 1);
            n_cmp++;
            if (byte_count !== exp_bc || load_data !== 1'b1) begin
                n_bad++;
                $display("FAIL wrap_byte%0d byte_count=%0d load=%b expected=%0d/1", i, byte_count, load_data, exp_bc);
            end
            tick();
        end
        $display("back_to_back: byte_count=%0d after 256 bytes", byte_count);
        do_stop();
    endtask

    task automatic test_async_reset();
        int r0;
        do_start();
        tick();
        send_bits(2);
        #2 n_rst = 1'b0;
        #1;
        $display("async_reset: outs=%h", outs);
        n_cmp++;
        if (outs !== 14'h0000) begin
            n_bad++;
            $display("FAIL async_reset outs=%h expected=%h", outs, 14'h0000);
        end
        tick();
        tick();
        n_rst = 1'b1;
        r0 = ren_cnt;
        tick();
        tick();
        tick();
        n_cmp++;
        if (outs !== 14'h0000 || ren_cnt != r0) begin
            n_bad++;
            $display("FAIL post_reset outs=%h reads=%0d expected=%h/0", outs, ren_cnt - r0, 14'h0000);
        end
        do_start();
        n_cmp++;
        if (outs !== 14'h2C00) begin
            n_bad++;
            $display("FAIL post_reset_load outs=%h expected=%h", outs, 14'h2C00);
        end
        do_stop();
    endtask

    initial begin
        test_reset();
        test_ack_byte();
        test_nack();
        test_underrun();
        test_stop();
        test_edge_rules();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_ctrl.md
TX_CTRL -- requirements
Module: tx_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-002 SHALL have port n_rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start_read, input, 1, one-cycle pulse: addressed for read, coincident with the SCL falling edge that ends the address-ACK bit.
REQ-004 SHALL have port stop_found, input, 1, one-cycle pulse: STOP condition detected.
REQ-005 SHALL have port rising_edge_found, input, 1, one-cycle pulse per SCL rising edge.
REQ-006 SHALL have port falling_edge_found, input, 1, one-cycle pulse per SCL falling edge.
REQ-007 SHALL have port sda_in, input, 1, synchronized SDA level.
REQ-008 SHALL have port fifo_empty, input, 1, TX FIFO holds no byte.
REQ-009 SHALL have port load_data, output, 1, one-cycle pulse; loads the downstream transmit shift register.
REQ-010 SHALL have port tx_enable, output, 1, qualifies shifting in the transmit shift register.
REQ-011 SHALL have port read_enable, output, 1, one-cycle TX FIFO pop.
REQ-012 SHALL have port sda_drive, output, 1, 1 = SDA driven from shift-register serial output; 0 = released.
REQ-013 SHALL have port master_nack, output, 1, one-cycle pulse: master NACKed a byte.
REQ-014 SHALL have port underrun, output, 1, one-cycle pulse: load attempted with fifo_empty=1.
REQ-015 SHALL have port byte_count, output, 8, bytes ACKed in the current read transfer.

Function
REQ-016 SHALL implement states IDLE, LOAD, SEND, ACK_WAIT, ACK_HOLD.
REQ-017 IDLE: outputs 0; start_read=1 -> LOAD next cycle, byte_count cleared to 0.
REQ-018 LOAD (exactly one cycle): load_data=1, sda_drive=1, read_enable=!fifo_empty, underrun=fifo_empty; bit counter cleared to 0; -> SEND.
REQ-019 SEND: tx_enable=1, sda_drive=1; each falling_edge_found increments the bit counter; the falling edge that makes the counter 8 -> ACK_WAIT.
REQ-020 ACK_WAIT: tx_enable=0, sda_drive=0; on rising_edge_found, latch sda_in into ack_bit -> ACK_HOLD.
REQ-021 ACK_HOLD: sda_drive=0; on falling_edge_found: ack_bit=0 -> byte_count+1 (wraps 255->0) and -> LOAD; ack_bit=1 -> master_nack=1 for that cycle and -> IDLE.
REQ-022 stop_found=1 SHALL force IDLE on the next edge from any state and take priority over all other inputs; byte_count is retained until the next start_read.
REQ-023 start_read in any state other than IDLE SHALL be ignored.
REQ-024 If rising_edge_found and falling_edge_found are both high, falling_edge_found SHALL be ignored that cycle.
REQ-025 Latency: load_data SHALL assert the cycle after start_read, and the cycle after an ACKed falling edge in ACK_HOLD.
REQ-026 Bit counter SHALL be 4 bits and never exceed 8.

Reset
REQ-027 n_rst=0 SHALL immediately set state IDLE, bit counter 0, ack_bit 1, byte_count 0, and all outputs 0, regardless of clk.
REQ-028 Reset asserted mid-byte SHALL abandon the byte; read_enable SHALL not be reissued after reset release.

Structure
REQ-029 The state enum typedef and the SDA drive constants SHALL reside in shared package i2c_pkg.
REQ-030 The bit counter SHALL be one flex_counter instance (NUM_CNT_BITS=4, rollover value 8); all other logic SHALL be in tx_ctrl.
REQ-031 All outputs SHALL be decoded from registered state only, with no combinational path from inputs to outputs except read_enable/underrun from fifo_empty in LOAD.

Verification
REQ-032 The bench SHALL cover: start_read, fifo_empty=0, 8 falling edges, ACK sda_in=0 -> one load_data and one read_enable, sda_drive high for 8 bits, byte_count=1, second LOAD.
REQ-033 The bench SHALL cover: one byte followed by NACK sda_in=1 -> master_nack pulse on the 9th falling edge, IDLE, byte_count=0.
REQ-034 The bench SHALL cover: start_read with fifo_empty=1 -> load_data=1, underrun=1, read_enable=0.
REQ-035 The bench SHALL cover: stop_found after 3 falling edges -> IDLE next cycle, sda_drive=0, no further load_data.
REQ-036 The bench SHALL cover: 256 ACKed bytes -> byte_count wraps to 0.
REQ-037 The bench SHALL cover: n_rst=0 mid-SEND -> all outputs 0 asynchronously; start_read after release -> normal LOAD.
